display_value_loader: RTL

//  Sequencer in front of the 4-digit 7-segment display path. Accepts a 14-bit binary

---
 rtl/display_value_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/display_value_loader.sv
// Binary-to-BCD loader for the 4-digit display: accepts a value, runs a double-dabble
// conversion over BIN_W cycles, then commits digits, blank mask and overflow together.
module display_value_loader #(
  parameter int BIN_W         = 14,
  parameter int DIGITS        = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      value_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int                BCD_W   = 4 * DIGITS;
  localparam int                CNT_W   = $clog2(BIN_W);
  localparam logic [31:0]       MAX_VAL = 32'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST =
    (BLANK_LEADING != 0) ? {{(DIGITS-1){1'b1}}, 1'b0} : {DIGITS{1'b0}};

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t            state;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BIN_W-1:0]  bin;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              ovf_in;
  logic [BIN_W-1:0]  load_val;
  logic [DIGITS-1:0] blank_nxt;

  assign ovf_in   = 32'(value_i) > MAX_VAL;
  assign load_val = ovf_in ? MAX_VAL[BIN_W-1:0] : value_i;

  // Add-3 correction happens before the shift, so a nibble never exceeds 9 going in.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit is blank only if it and every more significant digit are zero; ones never blanks.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    blank_nxt   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_zero  = higher_zero && (bcd[4*i +: 4] == 4'd0);
      blank_nxt[i] = higher_zero && (BLANK_LEADING != 0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bcd        <= '0;
      bin        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      ready_o    <= 1'b1;
      busy_o     <= 1'b0;
      digits_o   <= '0;
      blank_o    <= BLANK_RST;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            bin     <= load_val;
            bcd     <= '0;
            ovf     <= ovf_in;
            cnt     <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd <= {bcd_adj[BCD_W-2:0], bin[BIN_W-1]};
          bin <= {bin[BIN_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= COMMIT;
        end
        COMMIT: begin
          digits_o   <= bcd;
          blank_o    <= blank_nxt;
          overflow_o <= ovf;
          done_o     <= 1'b1;
          ready_o    <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
